// File: rtl/ofs_plat_hssi_reset_seq_pkg.sv
// Shared types and defaults for the HSSI transceiver reset sequencer.
package ofs_plat_hssi_reset_seq_pkg;

  // Sequencer states; the 3-bit encoding is also exported on the debug port.
  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_ANALOG_RST = 3'd1,
    ST_WAIT_CAL   = 3'd2,
    ST_TX_DIG     = 3'd3,
    ST_RX_LOCK    = 3'd4,
    ST_RX_DIG     = 3'd5,
    ST_READY      = 3'd6,
    ST_FAIL       = 3'd7
  } state_e;

  localparam int DEF_NUM_LANES = 4;
  localparam int DEF_T_ANALOG  = 16;
  localparam int DEF_T_LTD     = 64;
  localparam int DEF_TIMEOUT   = 4096;

  // Restart counter saturation value.
  localparam int RESTART_MAX   = 255;

  // The state timer is never narrower than this.
  localparam int TIMER_MIN_W   = 16;

  // Width of a timer able to reach 'timeout' without wrapping.
  function automatic int timer_width(input int timeout);
    int w;
    w = $clog2(timeout + 1);
    return (w < TIMER_MIN_W) ? TIMER_MIN_W : w;
  endfunction

endpackage

// File: rtl/ofs_plat_hssi_stable_detect.sv
// Counts consecutive cycles in which in_ok is high; stable flags the cycle
// that completes a run of T_LTD consecutive good cycles (and any after it).
module ofs_plat_hssi_stable_detect
  import ofs_plat_hssi_reset_seq_pkg::*;
#(
  parameter int T_LTD = DEF_T_LTD
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic in_ok,
  output logic stable
);

  localparam int CW = $clog2(T_LTD + 1);

  logic [CW-1:0] r_count;

  // Run-length counter: any bad cycle or clear restarts the run; saturates at T_LTD.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of block ordering.
    if (reset || clear) begin
      r_count <= '0;
    end else if (!in_ok) begin
      r_count <= '0;
    end else if (r_count != CW'(T_LTD)) begin
      r_count <= r_count + CW'(1);
    end
  end

  // The current good cycle counts toward the run, so T_LTD-1 prior cycles suffice.
  assign stable = in_ok && (r_count >= CW'(T_LTD - 1));

endmodule

// File: rtl/ofs_plat_hssi_reset_seq.sv
// HSSI transceiver reset sequencer: walks all lanes together through analog
// reset, calibration wait, TX digital release, CDR lock qualification and RX
// digital release, then monitors the link and restarts on loss of lock.
module ofs_plat_hssi_reset_seq
  import ofs_plat_hssi_reset_seq_pkg::*;
#(
  parameter int NUM_LANES = DEF_NUM_LANES,
  parameter int T_ANALOG  = DEF_T_ANALOG,
  parameter int T_LTD     = DEF_T_LTD,
  parameter int TIMEOUT   = DEF_TIMEOUT
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 f2a_tx_pll_locked,
  input  logic [NUM_LANES-1:0] f2a_tx_cal_busy,
  input  logic [NUM_LANES-1:0] f2a_rx_cal_busy,
  input  logic [NUM_LANES-1:0] f2a_rx_is_lockedtodata,
  output logic [NUM_LANES-1:0] a2f_tx_analogreset,
  output logic [NUM_LANES-1:0] a2f_rx_analogreset,
  output logic [NUM_LANES-1:0] a2f_tx_digitalreset,
  output logic [NUM_LANES-1:0] a2f_rx_digitalreset,
  output logic                 a2f_init_start,
  output logic                 link_ready,
  output logic                 error,
  output logic [7:0]           restart_count,
  output logic [2:0]           state
);

  localparam int TW = timer_width(TIMEOUT);

  state_e        r_state;
  state_e        w_next_state;
  logic [TW-1:0] r_timer;

  logic w_cal_done;
  logic w_all_locked;
  logic w_link_lost;
  logic w_timer_expired;
  logic w_analog_done;
  logic w_lock_clear;
  logic w_stable;

  logic w_analog_rst;
  logic w_tx_dig_rst;
  logic w_rx_dig_rst;
  logic w_init_start;
  logic w_link_ready;
  logic w_error;
  logic w_restart;

  logic       r_analog_rst;
  logic       r_tx_dig_rst;
  logic       r_rx_dig_rst;
  logic       r_init_start;
  logic       r_link_ready;
  logic       r_error;
  logic [7:0] r_restart_count;

  assign w_cal_done      = ~|{f2a_tx_cal_busy, f2a_rx_cal_busy};
  assign w_all_locked    = &f2a_rx_is_lockedtodata;
  assign w_link_lost     = !f2a_tx_pll_locked || !w_all_locked;
  // The timer reads 0 in the first cycle of a state, so N-1 marks the Nth cycle.
  assign w_timer_expired = (r_timer >= TW'(TIMEOUT - 1));
  assign w_analog_done   = (r_timer >= TW'(T_ANALOG - 1));
  assign w_lock_clear    = (r_state != ST_RX_LOCK);

  ofs_plat_hssi_stable_detect #(
    .T_LTD (T_LTD)
  ) u_stable_detect (
    .clk    (clk),
    .reset  (reset),
    .clear  (w_lock_clear),
    .in_ok  (w_all_locked),
    .stable (w_stable)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic; start is only honoured in IDLE, FAIL and READY.
  always_comb begin
    // NOTE: default every combinational output before the case so no path
    // leaves it unassigned, which would infer a latch.
    w_next_state = r_state;
    unique case (r_state)
      ST_IDLE, ST_FAIL: if (start) w_next_state = ST_ANALOG_RST;
      ST_ANALOG_RST:    if (w_analog_done) w_next_state = ST_WAIT_CAL;
      ST_WAIT_CAL: begin
        if (f2a_tx_pll_locked && w_cal_done) w_next_state = ST_TX_DIG;
        else if (w_timer_expired)            w_next_state = ST_FAIL;
      end
      ST_TX_DIG:        w_next_state = ST_RX_LOCK;
      ST_RX_LOCK: begin
        if (w_stable)             w_next_state = ST_RX_DIG;
        else if (w_timer_expired) w_next_state = ST_FAIL;
      end
      ST_RX_DIG:        w_next_state = ST_READY;
      ST_READY:         if (w_link_lost || start) w_next_state = ST_ANALOG_RST;
      default:          w_next_state = ST_IDLE;
    endcase
  end

  // Output decode from the upcoming state so registered outputs move with r_state.
  always_comb begin
    w_analog_rst = 1'b1;
    w_tx_dig_rst = 1'b1;
    w_rx_dig_rst = 1'b1;
    w_link_ready = 1'b0;
    w_error      = 1'b0;
    unique case (w_next_state)
      ST_WAIT_CAL: w_analog_rst = 1'b0;
      ST_TX_DIG, ST_RX_LOCK: begin
        w_analog_rst = 1'b0;
        w_tx_dig_rst = 1'b0;
      end
      ST_RX_DIG: begin
        w_analog_rst = 1'b0;
        w_tx_dig_rst = 1'b0;
        w_rx_dig_rst = 1'b0;
      end
      ST_READY: begin
        w_analog_rst = 1'b0;
        w_tx_dig_rst = 1'b0;
        w_rx_dig_rst = 1'b0;
        w_link_ready = 1'b1;
      end
      ST_FAIL: w_error = 1'b1;
      default: ;
    endcase
    w_init_start = (w_next_state == ST_ANALOG_RST) && (r_state != ST_ANALOG_RST);
    // Lock loss and start together still take this single path: one restart.
    w_restart    = (r_state == ST_READY) && (w_next_state == ST_ANALOG_RST);
  end

  // Output registers and saturating restart counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_analog_rst    <= 1'b1;
      r_tx_dig_rst    <= 1'b1;
      r_rx_dig_rst    <= 1'b1;
      r_init_start    <= 1'b0;
      r_link_ready    <= 1'b0;
      r_error         <= 1'b0;
      r_restart_count <= '0;
    end else begin
      r_analog_rst <= w_analog_rst;
      r_tx_dig_rst <= w_tx_dig_rst;
      r_rx_dig_rst <= w_rx_dig_rst;
      r_init_start <= w_init_start;
      r_link_ready <= w_link_ready;
      r_error      <= w_error;
      if (w_restart && (r_restart_count != 8'(RESTART_MAX))) begin
        r_restart_count <= r_restart_count + 8'd1;
      end
    end
  end

  // Cycles spent in the current state; cleared on every entry, never wraps.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_timer <= '0;
    end else if (w_next_state != r_state) begin
      r_timer <= '0;
    end else if (r_timer != '1) begin
      r_timer <= r_timer + TW'(1);
    end
  end

  assign a2f_tx_analogreset  = {NUM_LANES{r_analog_rst}};
  assign a2f_rx_analogreset  = {NUM_LANES{r_analog_rst}};
  assign a2f_tx_digitalreset = {NUM_LANES{r_tx_dig_rst}};
  assign a2f_rx_digitalreset = {NUM_LANES{r_rx_dig_rst}};
  assign a2f_init_start      = r_init_start;
  assign link_ready          = r_link_ready;
  assign error               = r_error;
  assign restart_count       = r_restart_count;
  assign state               = r_state;

endmodule
